// File: rtl/settings_bus_arbiter.sv
// Settings bus arbiter: shares one strobe/addr/data settings bus among NUM_PORTS valid/ready requesters.
// Define SETTINGS_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module settings_bus_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int AWIDTH    = 8,
  parameter int DWIDTH    = 32,
  parameter int GAP       = 0,
  localparam int IDW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        s_valid,
  output logic [NUM_PORTS-1:0]        s_ready,
  input  logic [NUM_PORTS*AWIDTH-1:0] s_addr,
  input  logic [NUM_PORTS*DWIDTH-1:0] s_data,
  output logic                        set_stb,
  output logic [AWIDTH-1:0]           set_addr,
  output logic [DWIDTH-1:0]           set_data,
  output logic [IDW-1:0]              grant_id,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, STB, HOLD} state_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] data;
  } req_t;

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit         ZERO_GAP = (GAP == 0);

  state_t                state, state_nxt;
  logic [3:0]            gap_cnt, gap_cnt_nxt;
  logic                  accept, sel_found, xfer;
  logic [IDW-1:0]        sel_idx;
  req_t [NUM_PORTS-1:0]  req;

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      assign req[g].addr = s_addr[g*AWIDTH +: AWIDTH];
      assign req[g].data = s_data[g*DWIDTH +: DWIDTH];
      assign s_ready[g]  = xfer && (sel_idx == IDW'(g));
    end
  endgenerate

`ifdef SETTINGS_ARB_FIXED_PRIO_EN
  // Descending scan so the lowest valid index is the last (winning) assignment.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (s_valid[k]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(k);
      end
    end
  end
`else
  localparam logic [IDW:0] NP = (IDW + 1)'(NUM_PORTS);

  logic [IDW-1:0] last_grant;
  logic [IDW:0]   cand;

  // Candidates last_grant+k for k=NUM_PORTS..1 wrapped mod NUM_PORTS; k=1 is
  // scanned last so the port nearest after last_grant wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = {1'b0, last_grant} + (IDW + 1)'(k);
      if (cand >= NP) cand = cand - NP;
      if (s_valid[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_grant <= IDW'(NUM_PORTS - 1);
    else if (xfer) last_grant <= sel_idx;
  end
`endif

  assign accept = (state == IDLE) || ((state == STB) && ZERO_GAP);
  assign xfer   = accept && sel_found;

  always_comb begin
    state_nxt   = state;
    gap_cnt_nxt = gap_cnt;
    case (state)
      IDLE: if (xfer) state_nxt = STB;
      STB: begin
        if (!ZERO_GAP) begin
          state_nxt   = HOLD;
          gap_cnt_nxt = GAP_LOAD;
        end else if (xfer) begin
          state_nxt = STB;
        end else begin
          state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
        else                 gap_cnt_nxt = gap_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gap_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      gap_cnt <= gap_cnt_nxt;
    end
  end

  // Bus fields are captured at accept and hold their value until the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_addr <= '0;
      set_data <= '0;
      grant_id <= '0;
    end else if (xfer) begin
      set_addr <= req[sel_idx].addr;
      set_data <= req[sel_idx].data;
      grant_id <= sel_idx;
    end
  end

  assign set_stb = (state == STB);
  assign busy    = (state != IDLE);

endmodule
